// File: rtl/tx_sequencer.sv
// tx_sequencer: serial frame sequencer (start bit, DATA_BITS payload LSB first,
// stop bit) paced by an external bit sample counter.
module tx_sequencer #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned SAMPLE_MAX = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic [3:0]           bsc_count,
   output logic                 bsc_en,
   output logic                 bsc_rst,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 tx_d, busy_d, done_d, bsc_en_d, bsc_rst_d;
   logic                 bit_end_c;
   logic                 last_bit_c;

   // End of a bit period: counter reports its final sample while enabled.
   assign bit_end_c  = bsc_en && (bsc_count == CNT_W'(SAMPLE_MAX));
   assign last_bit_c = (idx_q == IDX_W'(DATA_BITS - 1));

   // State, datapath and registered outputs; reset leaves the line idle high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_out  <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         bsc_en  <= 1'b0;
         bsc_rst <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_out  <= tx_d;
         busy    <= busy_d;
         done    <= done_d;
         bsc_en  <= bsc_en_d;
         bsc_rst <= bsc_rst_d;
      end
   end

   // Next-state and next-output logic; everything advances only on bit end.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      tx_d      = tx_out;
      busy_d    = busy;
      done_d    = 1'b0;
      bsc_en_d  = bsc_en;
      bsc_rst_d = bsc_rst;

      case (state_q)
         IDLE: begin
            // Line idle high, counter held cleared; accept a new frame on load.
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            bsc_en_d  = 1'b0;
            bsc_rst_d = 1'b0;
            if (load) begin
               state_d   = START;
               shift_d   = data_in;
               idx_d     = '0;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               bsc_en_d  = 1'b1;
               bsc_rst_d = 1'b1;
            end
         end

         START: begin
            if (bit_end_c) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end

         DATA: begin
            if (bit_end_c) begin
               if (last_bit_c) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  // Next payload bit is bit 1 of the pre-shift register.
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + IDX_W'(1);
                  tx_d    = shift_q[1];
               end
            end
         end

         STOP: begin
            if (bit_end_c) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               bsc_en_d  = 1'b0;
               bsc_rst_d = 1'b0;
               tx_d      = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
